// File: rtl/text_cell_fetcher8x8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_cell_fetcher8x8 : fetches 8x8 text cells from text RAM, maps palette
//                        indices to colors and streams pixels to the blender.
// Revision: 1.0
// ---------------------------------------------------------------------------
module text_cell_fetcher8x8 #(
  parameter int COLS   = 80,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_line_start,
  input  logic [9:0]        i_line,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_pixel_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_rd,
  input  logic [15:0]       i_ram_data,
  input  logic              i_pal_we,
  input  logic [3:0]        i_pal_idx,
  input  logic [11:0]       i_pal_color,
  output logic [7:0]        o_char,
  output logic [2:0]        o_row,
  output logic [2:0]        o_column,
  output logic [11:0]       o_fg_color,
  output logic [11:0]       o_bg_color,
  output logic              o_valid,
  output logic              o_line_done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_WAIT     = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [7:0] c_last_cell = 8'(COLS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_pix;
  logic              w_wrap;
  logic              w_last;
  logic              w_more;
  logic [8:0]        w_fetch_idx;
  logic [ADDR_W-1:0] w_line_addr;

  logic [ADDR_W-1:0] r_line_addr;
  logic [2:0]        r_row;
  logic [7:0]        r_cell_idx;
  logic [2:0]        r_col;
  logic [15:0]       r_cur;
  logic [15:0]       r_next;
  logic              r_next_valid;
  logic              r_rd_d;
  logic [11:0]       r_pal [16];

  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_rd;
  logic [7:0]        r_char;
  logic [2:0]        r_row_o;
  logic [2:0]        r_col_o;
  logic [11:0]       r_fg;
  logic [11:0]       r_bg;
  logic              r_valid;
  logic              r_line_done;

  assign w_line_addr = i_base_addr + ADDR_W'(i_line[9:3]) * ADDR_W'(COLS);

  // Cell to prefetch when a new cell becomes current: cell 1 on the initial
  // load, otherwise the one after the cell being promoted from r_next.
  assign w_fetch_idx = (r_state == ST_WAIT) ? 9'd1 : ({1'b0, r_cell_idx} + 9'd2);
  assign w_more      = (32'(w_fetch_idx) < 32'(COLS));

  always_comb begin
    w_state_nxt = r_state;
    w_pix       = 1'b0;
    w_wrap      = 1'b0;
    w_last      = 1'b0;
    if (i_line_start) begin
      w_state_nxt = ST_PREFETCH;
    end else begin
      case (r_state)
        ST_PREFETCH: w_state_nxt = ST_WAIT;
        ST_WAIT:     w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: begin
          if (i_pixel_en) begin
            w_pix  = 1'b1;
            w_wrap = (r_col == 3'd7);
            w_last = w_wrap && (r_cell_idx == c_last_cell);
            if (w_last) w_state_nxt = ST_DONE;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_addr  <= '0;
      r_row        <= '0;
      r_cell_idx   <= '0;
      r_col        <= '0;
      r_cur        <= '0;
      r_next       <= '0;
      r_next_valid <= 1'b0;
      r_rd_d       <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_rd     <= 1'b0;
      r_char       <= '0;
      r_row_o      <= '0;
      r_col_o      <= '0;
      r_fg         <= '0;
      r_bg         <= '0;
      r_valid      <= 1'b0;
      r_line_done  <= 1'b0;
      for (int i = 0; i < 16; i++) r_pal[i] <= {3{4'(i)}};
    end else begin
      r_ram_rd    <= 1'b0;
      r_rd_d      <= r_ram_rd;
      r_valid     <= w_pix;
      r_line_done <= w_last;

      // Lookups below read the pre-write entry, so a same-cycle write
      // only affects pixels from the following cycle on.
      if (i_pal_we) r_pal[i_pal_idx] <= i_pal_color;

      if (w_pix) begin
        r_char  <= r_cur[7:0];
        r_row_o <= r_row;
        r_col_o <= r_col;
        r_fg    <= r_pal[r_cur[11:8]];
        r_bg    <= r_pal[r_cur[15:12]];
      end

      if (i_line_start) begin
        r_line_addr  <= w_line_addr;
        r_row        <= i_line[2:0];
        r_cell_idx   <= '0;
        r_col        <= '0;
        r_next_valid <= 1'b0;
        r_ram_rd     <= 1'b1;
        r_ram_addr   <= w_line_addr;
      end else begin
        case (r_state)
          ST_WAIT: begin
            r_cur <= i_ram_data;
            if (w_more) begin
              r_ram_rd   <= 1'b1;
              r_ram_addr <= r_line_addr + ADDR_W'(w_fetch_idx);
            end
          end
          ST_ACTIVE: begin
            if (r_rd_d) begin
              r_next       <= i_ram_data;
              r_next_valid <= 1'b1;
            end
            if (w_pix) begin
              r_col <= r_col + 3'd1;
              if (w_wrap && !w_last) begin
                r_cell_idx   <= r_cell_idx + 8'd1;
                r_cur        <= r_next;
                r_next_valid <= 1'b0;
                if (w_more) begin
                  r_ram_rd   <= 1'b1;
                  r_ram_addr <= r_line_addr + ADDR_W'(w_fetch_idx);
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_ram_addr  = r_ram_addr;
  assign o_ram_rd    = r_ram_rd;
  assign o_char      = r_char;
  assign o_row       = r_row_o;
  assign o_column    = r_col_o;
  assign o_fg_color  = r_fg;
  assign o_bg_color  = r_bg;
  assign o_valid     = r_valid;
  assign o_line_done = r_line_done;

endmodule
`default_nettype wire
